// File: rtl/mbr_mem_ctrl.sv
// Memory buffer register with a variable-latency memory handshake.
// Fetches, stores or loads from ACC; stalls the control unit via busy.
module mbr_mem_ctrl #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       control_signal,
   input  logic [DATA_W-1:0] ACC_IN,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] MBR_OUT,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_WR_WAIT = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mbr;
   logic              r_req;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_rd;
   logic              w_wr;
   logic              w_ld;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_unused;

   assign w_rd      = control_signal[2];
   assign w_wr      = control_signal[3];
   assign w_ld      = control_signal[6];
   assign w_cnt_nxt = r_cnt + CNT_W'(1);
   assign w_unused  = ^{control_signal[31:7],
                        control_signal[5:4],
                        control_signal[1:0]};

   // Handshake FSM: command arbitration, wait/timeout, MBR capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mbr   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_rd) begin
                  r_state <= S_RD_WAIT;
                  r_req   <= 1'b1;
                  r_we    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end else if (w_wr) begin
                  r_state <= S_WR_WAIT;
                  r_req   <= 1'b1;
                  r_we    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end else if (w_ld) begin
                  r_mbr <= ACC_IN;
               end
            end
            S_RD_WAIT, S_WR_WAIT: begin
               // Ready beats the timeout when both land together.
               if (mem_ready) begin
                  if (r_state == S_RD_WAIT) r_mbr <= mem_rdata;
                  r_done  <= 1'b1;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                  r_err   <= 1'b1;
                  r_req   <= 1'b0;
                  r_we    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign mem_wdata = r_mbr;
   assign MBR_OUT   = r_mbr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_mbr_mem_ctrl.sv
// Testbench for mbr_mem_ctrl: randomized transactions against a
// transaction-level model of MBR contents and the sticky error flag.
module tb_mbr_mem_ctrl;

   localparam int DW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   control_signal;
   logic [DW-1:0] ACC_IN;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] MBR_OUT;
   logic          busy;
   logic          done;
   logic          err;

   int            checks = 0;
   int            failures = 0;
   logic [DW-1:0] m_mbr;
   logic          m_err;

   mbr_mem_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .control_signal(control_signal),
      .ACC_IN(ACC_IN), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .MBR_OUT(MBR_OUT), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      control_signal = '0;
      ACC_IN = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      m_mbr = '0;
      m_err = 1'b0;
      checks++;
      if (MBR_OUT !== 16'h0) begin
         failures++;
         $display("FAIL reset_mbr got=%h exp=0000", MBR_OUT);
      end
      checks++;
      if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=00000",
                  {mem_req, mem_we, busy, done, err});
      end
   endtask

   task automatic test_acc_load(input logic [DW-1:0] v);
      control_signal = 32'h40;
      ACC_IN = v;
      tick();
      control_signal = '0;
      m_mbr = v;
      checks++;
      if (MBR_OUT !== m_mbr) begin
         failures++;
         $display("FAIL acc_load got=%h exp=%h", MBR_OUT, m_mbr);
      end
      checks++;
      if ({busy, mem_req, done} !== 3'b0) begin
         failures++;
         $display("FAIL acc_load_ctl got=%b exp=000",
                  {busy, mem_req, done});
      end
   endtask

   task automatic test_idle_ready();
      mem_ready = 1'b1;
      mem_rdata = DW'($urandom);
      tick();
      mem_ready = 1'b0;
      checks++;
      if ({MBR_OUT, busy, done} !== {m_mbr, 2'b00}) begin
         failures++;
         $display("FAIL idle_ready got=%h/%b%b exp=%h/00",
                  MBR_OUT, busy, done, m_mbr);
      end
   endtask

   // rdy = wait cycle carrying mem_ready; 0 or > TO means never.
   task automatic test_txn(input bit is_wr, input int rdy,
                           input logic [DW-1:0] data, input bit noise,
                           input bit extra_cmds);
      bit ok;
      int n;
      ok = (rdy >= 1) && (rdy <= TO);
      n  = ok ? rdy : TO;
      control_signal = is_wr ? 32'h8 : 32'h4;
      if (extra_cmds) control_signal = control_signal | 32'h48;
      ACC_IN = DW'($urandom);
      tick();
      control_signal = '0;
      checks++;
      if ({mem_req, mem_we, busy, done} !== {1'b1, is_wr, 2'b10}) begin
         failures++;
         $display("FAIL txn_issue got=%b exp=%b",
                  {mem_req, mem_we, busy, done}, {1'b1, is_wr, 2'b10});
      end
      checks++;
      if (MBR_OUT !== m_mbr) begin
         failures++;
         $display("FAIL txn_issue_mbr got=%h exp=%h", MBR_OUT, m_mbr);
      end
      for (int k = 1; k <= n; k++) begin
         mem_ready = ok && (k == n);
         mem_rdata = (ok && k == n) ? data : DW'($urandom);
         if (noise) begin
            control_signal = $urandom | 32'h40;
            ACC_IN = 16'hAAAA;
         end
         checks++;
         if ({mem_req, mem_we, busy, done, mem_wdata} !==
             {1'b1, is_wr, 2'b10, m_mbr}) begin
            failures++;
            $display("FAIL txn_wait k=%0d got=%b%b%b%b/%h exp=1%b10/%h",
                     k, mem_req, mem_we, busy, done, mem_wdata,
                     is_wr, m_mbr);
         end
         tick();
         mem_ready = 1'b0;
         control_signal = '0;
      end
      if (ok) begin
         if (!is_wr) m_mbr = data;
      end else begin
         m_err = 1'b1;
      end
      checks++;
      if ({done, busy, mem_req} !== {ok, 2'b00}) begin
         failures++;
         $display("FAIL txn_end got=%b exp=%b",
                  {done, busy, mem_req}, {ok, 2'b00});
      end
      checks++;
      if ({MBR_OUT, err} !== {m_mbr, m_err}) begin
         failures++;
         $display("FAIL txn_end_mbr got=%h/%b exp=%h/%b",
                  MBR_OUT, err, m_mbr, m_err);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 2) == 0) test_acc_load(DW'($urandom));
         test_txn(1'($urandom_range(0, 1)), $urandom_range(1, TO),
                  DW'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_prio_reset();
      control_signal = 32'h4C;
      ACC_IN = 16'h5A5A;
      tick();
      control_signal = '0;
      checks++;
      if ({mem_req, mem_we, busy, MBR_OUT} !== {3'b101, m_mbr}) begin
         failures++;
         $display("FAIL prio got=%b%b%b/%h exp=101/%h",
                  mem_req, mem_we, busy, MBR_OUT, m_mbr);
      end
      tick();
      mem_ready = 1'b1;
      mem_rdata = 16'h1111;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_ready = 1'b0;
      m_mbr = '0;
      m_err = 1'b0;
      checks++;
      if ({mem_req, busy, done, err, MBR_OUT} !== {4'b0000, m_mbr}) begin
         failures++;
         $display("FAIL mid_reset got=%b%b%b%b/%h exp=0000/%h",
                  mem_req, busy, done, err, MBR_OUT, m_mbr);
      end
   endtask

   initial begin
      test_reset();
      test_acc_load(16'h1234);
      test_idle_ready();
      test_txn(1'b0, 3, 16'hBEEF, 1'b0, 1'b0);
      test_acc_load(16'h00FF);
      test_txn(1'b1, 4, 16'h0000, 1'b1, 1'b0);
      test_random();
      test_txn(1'b0, TO, 16'hC0DE, 1'b0, 1'b0);
      test_txn(1'b1, TO, 16'h0000, 1'b1, 1'b1);
      test_txn(1'b0, 1, 16'h7E57, 1'b0, 1'b0);
      test_txn(1'b0, 0, 16'hDEAD, 1'b0, 1'b0);
      test_idle_ready();
      test_txn(1'b1, 0, 16'h0000, 1'b1, 1'b0);
      test_txn(1'b0, 2, 16'h4242, 1'b0, 1'b0);
      test_prio_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
